// File: rtl/axi_switch_master.sv
// axi_switch_master: button-driven AXI-lite-style master, one transaction at a time.
// Define SWM_TIMEOUT_EN to abort handshakes stalled for TIMEOUT_CYCLES cycles.
module axi_switch_master #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_rd,
    input  logic       btn_wr,
    input  logic [3:0] sw_addr,
    input  logic [3:0] sw_data,
    output logic [3:0] SWM_arADDR,
    output logic [3:0] SWM_wdata,
    output logic       ms_arvalid,
    input  logic       sm_arready,
    output logic       ms_rready,
    input  logic       sm_rvalid,
    output logic       ms_awvalid,
    input  logic       sm_awready,
    output logic       ms_wvalid,
    input  logic       sm_wready,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic       last_op
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_AR,
        S_R,
        S_AWW,
        S_DONE
    } state_t;

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range 1..65535");
    end

    state_t     r_state;
    logic [3:0] r_addr;
    logic [3:0] r_wdata;
    logic       r_arvalid;
    logic       r_rready;
    logic       r_awvalid;
    logic       r_wvalid;
    logic       r_busy;
    logic       r_done;
    logic       r_err;
    logic       r_last_op;

    // [0],[1] synchronise, [2] holds the previous synchronised level
    logic [2:0] r_rd_sync;
    logic [2:0] r_wr_sync;
    // Masks edges until the sync chain holds real post-reset samples,
    // so a button held through reset release is not seen as a press.
    logic [2:0] r_live;

    logic w_rd_edge;
    logic w_wr_edge;
    logic w_ar_hs;
    logic w_r_hs;
    logic w_aw_hs;
    logic w_w_hs;
    logic w_aww_fin;
    logic w_expire;

    assign w_rd_edge = r_live[2] & r_rd_sync[1] & ~r_rd_sync[2];
    assign w_wr_edge = r_live[2] & r_wr_sync[1] & ~r_wr_sync[2];

    assign w_ar_hs   = r_arvalid & sm_arready;
    assign w_r_hs    = r_rready & sm_rvalid;
    assign w_aw_hs   = r_awvalid & sm_awready;
    assign w_w_hs    = r_wvalid & sm_wready;
    assign w_aww_fin = (~r_awvalid | w_aw_hs) & (~r_wvalid | w_w_hs);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd_sync <= '0;
            r_wr_sync <= '0;
            r_live    <= '0;
        end else begin
            r_rd_sync <= {r_rd_sync[1:0], btn_rd};
            r_wr_sync <= {r_wr_sync[1:0], btn_wr};
            r_live    <= {r_live[1:0], 1'b1};
        end
    end

`ifdef SWM_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_cnt;
    logic          w_wait;
    logic          w_exit;

    assign w_wait = (r_state == S_AR) || (r_state == S_R) ||
                    (r_state == S_AWW);
    assign w_exit = ((r_state == S_AR) && w_ar_hs) ||
                    ((r_state == S_R) && w_r_hs) ||
                    ((r_state == S_AWW) && w_aww_fin);
    assign w_expire = w_wait && !w_exit &&
                      (r_cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset || !w_wait || w_exit || w_expire) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_arvalid <= 1'b0;
            r_rready  <= 1'b0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
            r_last_op <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    // read wins a same-cycle tie
                    if (w_rd_edge) begin
                        r_addr    <= sw_addr;
                        r_last_op <= 1'b0;
                        r_err     <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_ISSUE;
                    end else if (w_wr_edge) begin
                        r_addr    <= sw_addr;
                        r_wdata   <= sw_data;
                        r_last_op <= 1'b1;
                        r_err     <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (r_last_op) begin
                        r_awvalid <= 1'b1;
                        r_wvalid  <= 1'b1;
                        r_state   <= S_AWW;
                    end else begin
                        r_arvalid <= 1'b1;
                        r_state   <= S_AR;
                    end
                end
                S_AR: begin
                    if (w_ar_hs) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= S_R;
                    end else if (w_expire) begin
                        r_arvalid <= 1'b0;
                        r_err     <= 1'b1;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_DONE;
                    end
                end
                S_R: begin
                    if (w_r_hs || w_expire) begin
                        r_rready <= 1'b0;
                        r_err    <= w_expire;
                        r_done   <= 1'b1;
                        r_busy   <= 1'b0;
                        r_state  <= S_DONE;
                    end
                end
                S_AWW: begin
                    if (w_aww_fin || w_expire) begin
                        r_awvalid <= 1'b0;
                        r_wvalid  <= 1'b0;
                        r_err     <= w_expire & ~w_aww_fin;
                        r_done    <= 1'b1;
                        r_busy    <= 1'b0;
                        r_state   <= S_DONE;
                    end else begin
                        if (w_aw_hs) r_awvalid <= 1'b0;
                        if (w_w_hs)  r_wvalid  <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign SWM_arADDR = r_addr;
    assign SWM_wdata  = r_wdata;
    assign ms_arvalid = r_arvalid;
    assign ms_rready  = r_rready;
    assign ms_awvalid = r_awvalid;
    assign ms_wvalid  = r_wvalid;
    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign last_op    = r_last_op;

endmodule

// File: tb/tb_axi_switch_master.sv
// tb_axi_switch_master: vector table plus corner sequences for axi_switch_master.
// Expected transactions are queued at press time and checked when done pulses.
module tb_axi_switch_master;

`ifdef SWM_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif
    localparam int NEVER = 1000;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_rd = 1'b0;
    logic       btn_wr = 1'b0;
    logic [3:0] sw_addr = '0;
    logic [3:0] sw_data = '0;
    logic [3:0] SWM_arADDR;
    logic [3:0] SWM_wdata;
    logic       ms_arvalid;
    logic       sm_arready = 1'b0;
    logic       ms_rready;
    logic       sm_rvalid = 1'b0;
    logic       ms_awvalid;
    logic       sm_awready = 1'b0;
    logic       ms_wvalid;
    logic       sm_wready = 1'b0;
    logic       busy;
    logic       done;
    logic       err;
    logic       last_op;

    axi_switch_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_rd     (btn_rd),
        .btn_wr     (btn_wr),
        .sw_addr    (sw_addr),
        .sw_data    (sw_data),
        .SWM_arADDR (SWM_arADDR),
        .SWM_wdata  (SWM_wdata),
        .ms_arvalid (ms_arvalid),
        .sm_arready (sm_arready),
        .ms_rready  (ms_rready),
        .sm_rvalid  (sm_rvalid),
        .ms_awvalid (ms_awvalid),
        .sm_awready (sm_awready),
        .ms_wvalid  (ms_wvalid),
        .sm_wready  (sm_wready),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .last_op    (last_op)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] addr;
        logic [3:0] wdata;
        bit         wr;
        bit         err;
        int         ar;
        int         r;
        int         aw;
        int         w;
        int         busy;
    } exp_t;

    typedef struct {
        bit         rd;
        bit         wr;
        logic [3:0] addr;
        logic [3:0] data;
        int         ard;
        int         rdd;
        int         awd;
        int         wd;
        logic [3:0] e_addr;
        bit         e_op;
        int         e_ar;
        int         e_r;
        int         e_aw;
        int         e_w;
        int         e_busy;
    } vec_t;

    int   n_vec = 0;
    int   n_bad = 0;
    int   n_done = 0;
    int   n_push = 0;
    exp_t sb[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // Slave: ready after d valid cycles; d < 0 means ready tied high.
    int ar_d = 0, r_d = 0, aw_d = 0, w_d = 0;
    int ar_n = 0, r_n = 0, aw_n = 0, w_n = 0;

    always @(negedge clk) begin
        sm_arready = (ar_d < 0) || (ms_arvalid && ar_n >= ar_d);
        sm_rvalid  = (r_d < 0) || (ms_rready && r_n >= r_d);
        sm_awready = (aw_d < 0) || (ms_awvalid && aw_n >= aw_d);
        sm_wready  = (w_d < 0) || (ms_wvalid && w_n >= w_d);
        ar_n = ms_arvalid ? ar_n + 1 : 0;
        r_n  = ms_rready ? r_n + 1 : 0;
        aw_n = ms_awvalid ? aw_n + 1 : 0;
        w_n  = ms_wvalid ? w_n + 1 : 0;
    end

    // Per-transaction monitor and scoreboard check
    int   c_ar, c_r, c_aw, c_w, c_busy;
    bit   moved;
    logic busy_q = 1'b0;
    logic done_q = 1'b0;

    always @(negedge clk) begin : mon
        exp_t e;
        if (busy && !busy_q) begin
            c_ar = 0; c_r = 0; c_aw = 0; c_w = 0; c_busy = 0;
            moved = 1'b0;
        end
        if (busy) begin
            c_busy++;
            c_ar += int'(ms_arvalid);
            c_r  += int'(ms_rready);
            c_aw += int'(ms_awvalid);
            c_w  += int'(ms_wvalid);
            if (sb.size() > 0) begin
                if (SWM_arADDR !== sb[0].addr) moved = 1'b1;
                if (sb[0].wr && SWM_wdata !== sb[0].wdata) moved = 1'b1;
            end
        end
        if (done) begin
            n_done++;
            chk("done_one_cycle", done_q, 0);
            chk("busy_low_at_done", busy, 0);
            if (sb.size() == 0) begin
                n_vec++;
                n_bad++;
                $display("FAIL unexpected_done: got done, expected none");
            end else begin
                e = sb.pop_front();
                chk("addr", SWM_arADDR, e.addr);
                if (e.wr) chk("wdata", SWM_wdata, e.wdata);
                chk("last_op", last_op, e.wr);
                chk("err", err, e.err);
                chk("arvalid_cycles", c_ar, e.ar);
                chk("rready_cycles", c_r, e.r);
                chk("awvalid_cycles", c_aw, e.aw);
                chk("wvalid_cycles", c_w, e.w);
                chk("busy_cycles", c_busy, e.busy);
                chk("outputs_stable", moved, 0);
            end
        end
        busy_q = busy;
        done_q = done;
    end

    task automatic push(input logic [3:0] a, input logic [3:0] d,
                        input bit wr, input bit er, input int ar,
                        input int r, input int aw, input int w,
                        input int b);
        exp_t e;
        e = '{addr: a, wdata: d, wr: wr, err: er, ar: ar, r: r,
              aw: aw, w: w, busy: b};
        sb.push_back(e);
        n_push++;
    endtask

    task automatic press(input bit r, input bit w, input logic [3:0] a,
                         input logic [3:0] d);
        @(negedge clk);
        sw_addr = a;
        sw_data = d;
        btn_rd  = r;
        btn_wr  = w;
        repeat (2) @(negedge clk);
        btn_rd = 1'b0;
        btn_wr = 1'b0;
    endtask

    task automatic wait_done();
        int start;
        int t;
        start = n_done;
        t = 0;
        while (n_done == start && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (n_done == start) begin
            n_vec++;
            n_bad++;
            $display("FAIL done_timeout: got no done, expected one");
        end
        repeat (2) @(negedge clk);
    endtask

    vec_t tbl[8];

    initial begin
        int start;
        int bc;
        int t;

        tbl[0] = '{1, 0, 4'd3, 4'd0, 0, 0, 0, 0, 4'd3, 0, 1, 1, 0, 0, 3};
        tbl[1] = '{0, 1, 4'd3, 4'd4, 0, 0, 0, 3, 4'd3, 1, 0, 0, 1, 4, 5};
        tbl[2] = '{1, 1, 4'd4, 4'd9, 0, 0, 0, 0, 4'd4, 0, 1, 1, 0, 0, 3};
        tbl[3] = '{1, 0, 4'hF, 4'd0, 2, 1, 0, 0, 4'hF, 0, 3, 2, 0, 0, 6};
        tbl[4] = '{0, 1, 4'd0, 4'hF, 0, 0, 2, 0, 4'd0, 1, 0, 0, 3, 1, 4};
        tbl[5] = '{0, 1, 4'hA, 4'd5, 0, 0, -1, -1, 4'hA, 1, 0, 0, 1, 1, 2};
        tbl[6] = '{1, 0, 4'd7, 4'd0, -1, -1, 0, 0, 4'd7, 0, 1, 1, 0, 0, 3};
        tbl[7] = '{0, 1, 4'd1, 4'hC, 0, 0, 1, 1, 4'd1, 1, 0, 0, 2, 2, 3};

        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err_op", {err, last_op}, 0);
        chk("rst_valids", {ms_arvalid, ms_rready, ms_awvalid, ms_wvalid}, 0);
        chk("rst_bus", {SWM_arADDR, SWM_wdata}, 0);
        reset = 1'b1;
        repeat (6) @(negedge clk);

        // Press-to-accept and accept-to-valid latency
        push(4'd2, 4'd0, 0, 0, 1, 1, 0, 0, 3);
        @(negedge clk);
        sw_addr = 4'd2;
        btn_rd  = 1'b1;
        @(negedge clk);
        chk("lat_busy_k", busy, 0);
        @(negedge clk);
        chk("lat_busy_k1", busy, 0);
        btn_rd = 1'b0;
        @(negedge clk);
        chk("lat_busy_k2", busy, 1);
        chk("lat_arvalid_k2", ms_arvalid, 0);
        @(negedge clk);
        chk("lat_arvalid_k3", ms_arvalid, 1);
        wait_done();

        for (int i = 0; i < 8; i++) begin
            ar_d = tbl[i].ard;
            r_d  = tbl[i].rdd;
            aw_d = tbl[i].awd;
            w_d  = tbl[i].wd;
            push(tbl[i].e_addr, tbl[i].data, tbl[i].e_op, 0, tbl[i].e_ar,
                 tbl[i].e_r, tbl[i].e_aw, tbl[i].e_w, tbl[i].e_busy);
            press(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].data);
            wait_done();
        end
        ar_d = 0; r_d = 0; aw_d = 0; w_d = 0;
        repeat (2) @(negedge clk);

        // Presses while a stalled read is in flight are discarded
        ar_d = 6;
        start = n_done;
        push(4'd5, 4'd0, 0, 0, 7, 1, 0, 0, 9);
        press(1, 0, 4'd5, 4'd0);
        @(negedge clk);
        sw_addr = 4'd9;
        sw_data = 4'd1;
        btn_wr  = 1'b1;
        repeat (2) @(negedge clk);
        btn_wr = 1'b0;
        @(negedge clk);
        btn_rd = 1'b1;
        repeat (2) @(negedge clk);
        btn_rd = 1'b0;
        wait_done();
        repeat (20) @(negedge clk);
        chk("busy_press_done_count", n_done - start, 1);
        chk("busy_press_idle", busy, 0);
        ar_d = 0;

        // Reset mid-write with btn_wr held through release
        aw_d = 0;
        w_d  = NEVER;
        @(negedge clk);
        sw_addr = 4'd6;
        sw_data = 4'd3;
        btn_wr  = 1'b1;
        t = 0;
        while (!ms_wvalid && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("midwr_wvalid_seen", ms_wvalid, 1);
        repeat (2) @(negedge clk);
        start = n_done;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_valids",
            {ms_arvalid, ms_rready, ms_awvalid, ms_wvalid}, 0);
        chk("midrst_status", {busy, done, err, last_op}, 0);
        chk("midrst_bus", {SWM_arADDR, SWM_wdata}, 0);
        @(negedge clk);
        reset = 1'b1;
        w_d   = 0;
        bc = 0;
        repeat (12) begin
            @(negedge clk);
            bc += int'(busy);
        end
        chk("held_btn_no_cmd", bc, 0);
        chk("midrst_no_done", n_done - start, 0);
        btn_wr = 1'b0;
        repeat (3) @(negedge clk);
        push(4'd6, 4'd3, 1, 0, 0, 0, 1, 1, 2);
        press(0, 1, 4'd6, 4'd3);
        wait_done();

`ifdef SWM_TIMEOUT_EN
        // Stuck arready: abort after TO cycles with err set
        ar_d = NEVER;
        push(4'd8, 4'd0, 0, 1, TO, 0, 0, 0, TO + 1);
        press(1, 0, 4'd8, 4'd0);
        wait_done();
        chk("err_held_idle", err, 1);
        ar_d = 0;
        push(4'd2, 4'd0, 0, 0, 1, 1, 0, 0, 3);
        press(1, 0, 4'd2, 4'd0);
        @(negedge clk);
        chk("err_cleared_on_accept", err, 0);
        wait_done();
`endif

        chk("scoreboard_empty", sb.size(), 0);
        chk("done_total", n_done, n_push);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/axi_switch_master.md
# axi_switch_master

Upstream AXI-lite-style master for the `tt_um_thejesvinii_axi` slave.
- Turns operator inputs (read/write buttons, 4-bit address and data switches) into properly sequenced `ms_*` valid/ready handshakes on the slave's `SWM_arADDR`/`SWM_wdata` bus.
- Reports busy/done/error status.
- Allows one transaction in flight; no queueing.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: max cycles spent in any handshake state before abort (only with `SWM_TIMEOUT_EN`); range 1..65535.

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-low reset (sampled on `clk`; 0 = reset)
- `btn_rd`  in  1  raw read button, asynchronous, active-high
- `btn_wr`  in  1  raw write button, asynchronous, active-high
- `sw_addr`  in  4  target address switches
- `sw_data`  in  4  write data switches
- `SWM_arADDR`  out  4  address to slave, shared by read and write
- `SWM_wdata`  out  4  write data to slave
- `ms_arvalid`  out  1  read address valid
- `sm_arready`  in  1  read address ready
- `ms_rready`  out  1  read data ready
- `sm_rvalid`  in  1  read data valid
- `ms_awvalid`  out  1  write address valid
- `sm_awready`  in  1  write address ready
- `ms_wvalid`  out  1  write data valid
- `sm_wready`  in  1  write data ready
- `busy`  out  1  high from command accept until `done`
- `done`  out  1  one-cycle pulse at transaction end
- `err`  out  1  last transaction timed out; held until next accept
- `last_op`  out  1  0 = last command was read, 1 = write

## Operation
Button conditioning:
- Each button goes through a 2-flop synchroniser, then a rising-edge detector.
- A button held high through reset release must not produce a command.

Command accept (IDLE only):
- On a detected edge, latch `sw_addr`→`SWM_arADDR`; for write, also `sw_data`→`SWM_wdata`.
- Set `last_op`, clear `err`, set `busy`.
- Address and data outputs stay stable until the next accept.
- Edges seen in any non-IDLE state are discarded.
- Simultaneous rd and wr edges: read wins, write discarded.

FSM states:
- IDLE → AR (read) or AWW (write) on accept.
- AR: `ms_arvalid`=1; on `ms_arvalid & sm_arready` → R.
- R: `ms_rready`=1; on `sm_rvalid & ms_rready` → DONE.
- AWW: `ms_awvalid`=1 and `ms_wvalid`=1.
  - Each valid drops the cycle after its own handshake (`valid & ready`).
  - Both handshakes in the same cycle is legal.
  - Exit to DONE once both have completed.
- DONE: `done`=1 for one cycle, `busy` cleared, → IDLE.

Handshake rules:
- A valid, once asserted, is held until its handshake completes.
- Valid assertion never waits on ready.
- Ready arriving before valid has no effect.

Reset:
- All outputs 0, FSM in IDLE, synchroniser/edge state cleared.
- Reset mid-transaction drops all valids/readys at the next edge with no `done` pulse.

## Timing
- Button high at first sampling edge k → command accepted at edge k+2 → valid(s) high after edge k+3.
- Read with slave ready tied high: AR 1 cycle, R 1 cycle, DONE 1 cycle; `done` 3 cycles after accept.
- Write with both readys high: AWW 1 cycle, DONE 1 cycle.
- Back-to-back: a new accept is possible on the first IDLE cycle after DONE.
- `busy` deasserts at the same edge `done` asserts.

## Configuration
- `SWM_TIMEOUT_EN` defined: a cycle counter (width sized to `TIMEOUT_CYCLES`) clears on entry to each of AR, R, AWW.
  - If it reaches `TIMEOUT_CYCLES` without exit: drop all valids/readys, set `err`, go to DONE (pulse `done`), → IDLE.
- `SWM_TIMEOUT_EN` undefined: no counter; FSM waits indefinitely; `err` tied 0.

## Test plan
- Read, addr 3, readys immediate: `btn_rd` pulse with `sw_addr`=3 → `SWM_arADDR`=3, `ms_arvalid` 1 cycle, `ms_rready` 1 cycle, `done` pulse, `last_op`=0.
- Write, addr 3 data 4, `sm_wready` delayed 3 cycles after `sm_awready`:
  - `ms_awvalid` drops after 1 cycle; `ms_wvalid` held 4 cycles.
  - `SWM_wdata`=4 stable throughout; single `done`; `last_op`=1.
- Same-cycle rd+wr edges with `sw_addr`=4 → read to addr 4 only; no `ms_awvalid`/`ms_wvalid` ever asserted.
- Button pressed while busy (AR stalled) → ignored; exactly one transaction and one `done`.
- `SWM_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, `sm_arready` stuck 0 → `ms_arvalid` drops after 8 cycles, `err`=1, `done` pulses; next command clears `err`.
- Reset asserted in the middle of a write, and `btn_wr` held through reset → outputs 0, no `done`, no command after release until `btn_wr` re-pressed.
